// File: rtl/rs_alu_if.sv
// Bus bundle between dispatch/CDB producers, the ALU reservation station and the ALU.
// The slave modport is the reservation station's view; master is the driving side.
interface rs_alu_if #(
    parameter int ROB_W = 4
);
    // dispatch side
    logic              clear;
    logic              in_valid;
    logic [10:0]       in_op;
    logic              in_qj_has;
    logic [ROB_W-1:0]  in_qj;
    logic [31:0]       in_vj;
    logic              in_qk_has;
    logic [ROB_W-1:0]  in_qk;
    logic [31:0]       in_vk;
    logic [31:0]       in_pc;
    logic [31:0]       in_imm;
    logic [ROB_W-1:0]  in_rob_id;
    // common data bus ports
    logic              alu_cdb_valid;
    logic [ROB_W-1:0]  alu_cdb_rob;
    logic [31:0]       alu_cdb_val;
    logic              lsb_cdb_valid;
    logic [ROB_W-1:0]  lsb_cdb_rob;
    logic [31:0]       lsb_cdb_val;
    // status and issue bus
    logic              full;
    logic              alu_yes;
    logic [10:0]       alu_op;
    logic [31:0]       alu_v1;
    logic [31:0]       alu_v2;
    logic [31:0]       alu_pc;
    logic [31:0]       alu_imm;
    logic [ROB_W-1:0]  alu_rob_id;

    modport slave (
        input  clear, in_valid, in_op, in_qj_has, in_qj, in_vj, in_qk_has, in_qk, in_vk,
               in_pc, in_imm, in_rob_id,
               alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
               lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val,
        output full, alu_yes, alu_op, alu_v1, alu_v2, alu_pc, alu_imm, alu_rob_id
    );

    modport master (
        output clear, in_valid, in_op, in_qj_has, in_qj, in_vj, in_qk_has, in_qk, in_vk,
               in_pc, in_imm, in_rob_id,
               alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
               lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val,
        input  full, alu_yes, alu_op, alu_v1, alu_v2, alu_pc, alu_imm, alu_rob_id
    );
endinterface

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: holds dispatched instructions until both
// operands are known (snooping the ALU and LSB CDB ports) and issues the lowest-index
// ready entry, one per cycle, on a registered ALU input bus.
module rs_alu #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    rs_alu_if.slave  bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Resolve one pending operand against both CDB ports; ALU port takes precedence.
    // Returns {still_pending, value}.
    function automatic logic [32:0] capture(
        input logic             has,
        input logic [ROB_W-1:0] q,
        input logic [31:0]      v,
        input logic             a_valid,
        input logic [ROB_W-1:0] a_rob,
        input logic [31:0]      a_val,
        input logic             l_valid,
        input logic [ROB_W-1:0] l_rob,
        input logic [31:0]      l_val
    );
        logic [32:0] res;
        if (has && a_valid && (q == a_rob)) begin
            res = {1'b0, a_val};
        end else if (has && l_valid && (q == l_rob)) begin
            res = {1'b0, l_val};
        end else begin
            res = {has, v};
        end
        return res;
    endfunction

    // entry storage
    logic [RS_SIZE-1:0] busy_r;
    logic [RS_SIZE-1:0] qj_has_r;
    logic [RS_SIZE-1:0] qk_has_r;
    logic [10:0]        op_r  [RS_SIZE];
    logic [ROB_W-1:0]   qj_r  [RS_SIZE];
    logic [ROB_W-1:0]   qk_r  [RS_SIZE];
    logic [ROB_W-1:0]   rob_r [RS_SIZE];
    logic [31:0]        vj_r  [RS_SIZE];
    logic [31:0]        vk_r  [RS_SIZE];
    logic [31:0]        pc_r  [RS_SIZE];
    logic [31:0]        imm_r [RS_SIZE];

    // issue bus registers
    logic               alu_yes_r;
    logic [10:0]        alu_op_r;
    logic [31:0]        alu_v1_r;
    logic [31:0]        alu_v2_r;
    logic [31:0]        alu_pc_r;
    logic [31:0]        alu_imm_r;
    logic [ROB_W-1:0]   alu_rob_id_r;

    // selection and capture results
    logic [RS_SIZE-1:0] ready_s;
    logic               full_s;
    logic               sel_found_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic [32:0]        wake_j_s [RS_SIZE];
    logic [32:0]        wake_k_s [RS_SIZE];
    logic [32:0]        disp_j_s;
    logic [32:0]        disp_k_s;

    // Ready vector plus lowest-index picks for issue and for the free slot, from registered state only.
    always_comb begin
        ready_s     = busy_r & ~qj_has_r & ~qk_has_r;
        full_s      = &busy_r;
        sel_found_s = |ready_s;
        sel_idx_s   = '0;
        free_idx_s  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            sel_idx_s  = ready_s[i] ? IDX_W'(i) : sel_idx_s;
            free_idx_s = busy_r[i]  ? free_idx_s : IDX_W'(i);
        end
    end

    // Operand capture for held entries (wake-up) and for the incoming instruction (bypass).
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j_s[i] = capture(qj_has_r[i], qj_r[i], vj_r[i],
                                  bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_val,
                                  bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_val);
            wake_k_s[i] = capture(qk_has_r[i], qk_r[i], vk_r[i],
                                  bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_val,
                                  bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_val);
        end
        disp_j_s = capture(bus.in_qj_has, bus.in_qj, bus.in_vj,
                           bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_val,
                           bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_val);
        disp_k_s = capture(bus.in_qk_has, bus.in_qk, bus.in_vk,
                           bus.alu_cdb_valid, bus.alu_cdb_rob, bus.alu_cdb_val,
                           bus.lsb_cdb_valid, bus.lsb_cdb_rob, bus.lsb_cdb_val);
    end

    // Entry and issue-bus update: reset, then stall hold, then flush, else wake/issue/dispatch together.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_r       <= '0;
            qj_has_r     <= '0;
            qk_has_r     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]  <= 11'd0;
                qj_r[i]  <= '0;
                qk_r[i]  <= '0;
                rob_r[i] <= '0;
                vj_r[i]  <= 32'd0;
                vk_r[i]  <= 32'd0;
                pc_r[i]  <= 32'd0;
                imm_r[i] <= 32'd0;
            end
            alu_yes_r    <= 1'b0;
            alu_op_r     <= 11'd0;
            alu_v1_r     <= 32'd0;
            alu_v2_r     <= 32'd0;
            alu_pc_r     <= 32'd0;
            alu_imm_r    <= 32'd0;
            alu_rob_id_r <= '0;
        end else if (rdy_in) begin
            if (bus.clear) begin
                busy_r    <= '0;
                alu_yes_r <= 1'b0;
            end else begin
                // wake-up: only busy entries listen; a ready entry has nothing pending
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_r[i]) begin
                        qj_has_r[i] <= wake_j_s[i][32];
                        vj_r[i]     <= wake_j_s[i][31:0];
                        qk_has_r[i] <= wake_k_s[i][32];
                        vk_r[i]     <= wake_k_s[i][31:0];
                    end
                end
                // issue: the selected entry is never the dispatch target (that one is free)
                if (sel_found_s) begin
                    busy_r[sel_idx_s] <= 1'b0;
                    alu_yes_r         <= 1'b1;
                    alu_op_r          <= op_r[sel_idx_s];
                    alu_v1_r          <= vj_r[sel_idx_s];
                    alu_v2_r          <= vk_r[sel_idx_s];
                    alu_pc_r          <= pc_r[sel_idx_s];
                    alu_imm_r         <= imm_r[sel_idx_s];
                    alu_rob_id_r      <= rob_r[sel_idx_s];
                end else begin
                    alu_yes_r         <= 1'b0;
                end
                // dispatch into the lowest free slot; full is judged before this edge's issue
                if (bus.in_valid && !full_s) begin
                    busy_r[free_idx_s]   <= 1'b1;
                    op_r[free_idx_s]     <= bus.in_op;
                    qj_has_r[free_idx_s] <= disp_j_s[32];
                    vj_r[free_idx_s]     <= disp_j_s[31:0];
                    qj_r[free_idx_s]     <= bus.in_qj;
                    qk_has_r[free_idx_s] <= disp_k_s[32];
                    vk_r[free_idx_s]     <= disp_k_s[31:0];
                    qk_r[free_idx_s]     <= bus.in_qk;
                    pc_r[free_idx_s]     <= bus.in_pc;
                    imm_r[free_idx_s]    <= bus.in_imm;
                    rob_r[free_idx_s]    <= bus.in_rob_id;
                end
            end
        end
    end

    assign bus.full       = full_s;
    assign bus.alu_yes    = alu_yes_r;
    assign bus.alu_op     = alu_op_r;
    assign bus.alu_v1     = alu_v1_r;
    assign bus.alu_v2     = alu_v2_r;
    assign bus.alu_pc     = alu_pc_r;
    assign bus.alu_imm    = alu_imm_r;
    assign bus.alu_rob_id = alu_rob_id_r;
endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: stimulus pushes expected issues (with the cycle they must
// appear in) into a queue; a negedge monitor pops and compares every new issue.
module tb_rs_alu;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    rs_alu_if #(.ROB_W(4)) bus ();

    rs_alu #(.RS_SIZE(8), .ROB_W(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    // free-running clock
    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        logic [10:0] op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc       = 0;
    logic rdy_q     = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // edge counter and the rdy value each edge actually used
    always @(posedge clk_in) begin
        cyc   <= cyc + 1;
        rdy_q <= rdy_in;
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // monitor: a new issue is alu_yes high after an edge taken with rdy_in=1
    always @(negedge clk_in) begin
        if (bus.alu_yes === 1'b1 && rdy_q === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_issue: got issue rob_id %0d at cycle %0d, required none",
                         bus.alu_rob_id, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_fields",
                    160'({bus.alu_op, bus.alu_v1, bus.alu_v2, bus.alu_pc, bus.alu_imm, bus.alu_rob_id}),
                    160'({mon_e.op, mon_e.v1, mon_e.v2, mon_e.pc, mon_e.imm, mon_e.rob}));
                chk("issue_cycle", 160'(cyc), 160'(mon_e.cyc));
            end
        end
    end

    task automatic idle();
        bus.clear         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_op         = 11'd0;
        bus.in_qj_has     = 1'b0;
        bus.in_qj         = 4'd0;
        bus.in_vj         = 32'd0;
        bus.in_qk_has     = 1'b0;
        bus.in_qk         = 4'd0;
        bus.in_vk         = 32'd0;
        bus.in_pc         = 32'd0;
        bus.in_imm        = 32'd0;
        bus.in_rob_id     = 4'd0;
        bus.alu_cdb_valid = 1'b0;
        bus.alu_cdb_rob   = 4'd0;
        bus.alu_cdb_val   = 32'd0;
        bus.lsb_cdb_valid = 1'b0;
        bus.lsb_cdb_rob   = 4'd0;
        bus.lsb_cdb_val   = 32'd0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    // drive one dispatch for the coming edge; immediate is ~pc so it is distinct per instruction
    task automatic disp(input logic [10:0] op, input logic qjh, input logic [3:0] qj, input logic [31:0] vj,
                        input logic qkh, input logic [3:0] qk, input logic [31:0] vk,
                        input logic [31:0] pc, input logic [3:0] rob);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_qj_has = qjh;
        bus.in_qj     = qj;
        bus.in_vj     = vj;
        bus.in_qk_has = qkh;
        bus.in_qk     = qk;
        bus.in_vk     = vk;
        bus.in_pc     = pc;
        bus.in_imm    = ~pc;
        bus.in_rob_id = rob;
    endtask

    task automatic expect_issue(input int at, input logic [10:0] op, input logic [31:0] v1,
                                input logic [31:0] v2, input logic [31:0] pc, input logic [3:0] rob);
        exp_t e;
        e.cyc = at; e.op = op; e.v1 = v1; e.v2 = v2; e.pc = pc; e.imm = ~pc; e.rob = rob;
        exp_q.push_back(e);
    endtask

    int base;

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        repeat (2) step();
        rst_in = 1'b0;

        // reset state
        chk("rst_full",    160'(bus.full),       160'(1'b0));
        chk("rst_yes",     160'(bus.alu_yes),    160'(1'b0));
        chk("rst_op",      160'(bus.alu_op),     160'(11'd0));
        chk("rst_v1",      160'(bus.alu_v1),     160'(32'd0));
        chk("rst_rob",     160'(bus.alu_rob_id), 160'(4'd0));

        // 1: ready add issues the cycle after dispatch, then alu_yes drops
        disp(11'h033, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 32'h100, 4'd3);
        expect_issue(cyc + 2, 11'h033, 32'd5, 32'd7, 32'h100, 4'd3);
        step();
        chk("t1_no_early", 160'(bus.alu_yes), 160'(1'b0));
        step();
        chk("t1_yes", 160'(bus.alu_yes), 160'(1'b1));
        step();
        chk("t1_yes_drop", 160'(bus.alu_yes), 160'(1'b0));

        // 2: src1 waits on rob 2, woken by LSB CDB two cycles later
        disp(11'h433, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1, 32'h104, 4'd4);
        step();
        step();
        bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = 4'd2; bus.lsb_cdb_val = 32'h10;
        expect_issue(cyc + 2, 11'h433, 32'h10, 32'd1, 32'h104, 4'd4);
        repeat (3) step();

        // 3: dispatch bypass from ALU CDB on src2
        disp(11'h133, 1'b0, 4'd0, 32'd3, 1'b1, 4'd5, 32'hDEAD, 32'h108, 4'd5);
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob = 4'd5; bus.alu_cdb_val = 32'd9;
        expect_issue(cyc + 2, 11'h133, 32'd3, 32'd9, 32'h108, 4'd5);
        repeat (3) step();

        // 4: fill all eight entries, reject a ninth, drain via CDB
        for (int i = 0; i < 8; i++) begin
            disp(11'h033, 1'b1, (i == 6) ? 4'd1 : 4'd7, 32'd0, 1'b0, 4'd0, 32'(i),
                 32'h200 + 32'(4 * i), 4'(i));
            step();
        end
        chk("t4_full", 160'(bus.full), 160'(1'b1));
        disp(11'h037, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'h2F0, 4'd8);
        step();
        chk("t4_full_after_reject", 160'(bus.full), 160'(1'b1));
        bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = 4'd1; bus.lsb_cdb_val = 32'h77;
        expect_issue(cyc + 2, 11'h033, 32'h77, 32'd6, 32'h218, 4'd6);
        step();
        chk("t4_full_at_wake", 160'(bus.full), 160'(1'b1));
        step();
        chk("t4_full_after_issue", 160'(bus.full), 160'(1'b0));
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob = 4'd7; bus.alu_cdb_val = 32'h55;
        base = cyc;
        for (int k = 0; k < 7; k++) begin
            int e_idx;
            e_idx = (k < 6) ? k : 7;
            expect_issue(base + 2 + k, 11'h033, 32'h55, 32'(e_idx), 32'h200 + 32'(4 * e_idx), 4'(e_idx));
        end
        repeat (10) step();

        // 5: two entries woken together issue back to back, lowest index first
        disp(11'h0B3, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'hA, 32'h300, 4'd10);
        step();
        disp(11'h0B3, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'hB, 32'h304, 4'd11);
        step();
        bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = 4'd9; bus.lsb_cdb_val = 32'h99;
        expect_issue(cyc + 2, 11'h0B3, 32'h99, 32'hA, 32'h300, 4'd10);
        expect_issue(cyc + 3, 11'h0B3, 32'h99, 32'hB, 32'h304, 4'd11);
        repeat (4) step();

        // 6a: clear flushes waiting and ready entries, and the dispatch of that cycle
        for (int i = 0; i < 3; i++) begin
            disp(11'h033, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'(i), 32'h500 + 32'(4 * i), 4'(i));
            step();
        end
        disp(11'h033, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'h510, 4'd13);
        step();
        disp(11'h037, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 32'h514, 4'd14);
        bus.clear = 1'b1;
        step();
        chk("t6_clear_yes",  160'(bus.alu_yes), 160'(1'b0));
        chk("t6_clear_full", 160'(bus.full),    160'(1'b0));
        bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = 4'd12; bus.lsb_cdb_val = 32'h5;
        repeat (4) step();

        // 6b: stall holds alu_yes and defers the next issue until rdy returns
        disp(11'h033, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22, 32'h400, 4'd14);
        expect_issue(cyc + 2, 11'h033, 32'h11, 32'h22, 32'h400, 4'd14);
        step();
        disp(11'h233, 1'b0, 4'd0, 32'h33, 1'b0, 4'd0, 32'h44, 32'h404, 4'd15);
        expect_issue(cyc + 5, 11'h233, 32'h33, 32'h44, 32'h404, 4'd15);
        step();
        rdy_in = 1'b0;
        disp(11'h037, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h77, 32'h408, 4'd1);
        step();
        step();
        step();
        chk("t6_stall_hold_yes", 160'(bus.alu_yes),    160'(1'b1));
        chk("t6_stall_hold_rob", 160'(bus.alu_rob_id), 160'(4'd14));
        rdy_in = 1'b1;
        repeat (4) step();

        chk("queue_drained", 160'(exp_q.size()), 160'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
